// File: rtl/ppb_input_conditioner.sv
// -----------------------------------------------------------------------------
// ppb_input_conditioner
//
// Panel-side front end of the PPB link. Every raw panel bit is synchronised
// into the clock domain and debounced. Level bits are presented as clean
// debounced levels. Momentary bits (PULSE_MASK set) become one-cycle pulses on
// each debounced press. The output vector keeps the [0:N_IN-1] bit order that
// the PPB mapping block consumes.
//
// Ports
//   clk            system clock, all state on the rising edge
//   reset          asynchronous, active-high reset
//   raw_inputs     [0:N_IN-1] unsynchronised panel levels
//   device_inputs  [0:N_IN-1] conditioned vector to the PPB mapping
//   input_changed  one-cycle strobe: some level bit changed on the previous edge
// -----------------------------------------------------------------------------
module ppb_input_conditioner #(
   parameter int               N_IN            = 60,
   parameter int               SYNC_STAGES     = 2,
   parameter int               DEBOUNCE_CYCLES = 100000,
   // Index 0 is the MSB, so vector index i sits at numeric bit N_IN-1-i.
   // The default marks clk_step (index 1) and AR_load (index 13).
   parameter logic [0:N_IN-1]  PULSE_MASK      = (N_IN'(1) << (N_IN - 2)) |
                                                 (N_IN'(1) << (N_IN - 14))
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [0:N_IN-1]   raw_inputs,
   output logic [0:N_IN-1]   device_inputs,
   output logic              input_changed
);

   localparam int               CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic [0:N_IN-1]  sync_q [SYNC_STAGES];
   logic [0:N_IN-1]  sync_out;
   logic [0:N_IN-1]  stable;
   logic [0:N_IN-1]  stable_d;
   logic [0:N_IN-1]  pulse_q;
   logic [CNT_W-1:0] cnt_q [N_IN];

   // Plain flop chain: nothing may sit between the synchroniser stages.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int k = 0; k < SYNC_STAGES; k++) begin
            sync_q[k] <= '0;
         end
      end else begin
         // NOTE: sequential state uses non-blocking assignments so every stage
         // samples the value its predecessor held before this edge.
         sync_q[0] <= raw_inputs;
         for (int k = 1; k < SYNC_STAGES; k++) begin
            sync_q[k] <= sync_q[k-1];
         end
      end
   end

   assign sync_out = sync_q[SYNC_STAGES-1];

   // Per-bit debouncer: a new level is accepted only after it has differed
   // from the stable level for DEBOUNCE_CYCLES consecutive edges. Any return
   // to the stable level clears the count, and the count is cleared again at
   // acceptance, so it never wraps.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         stable <= '0;
         // NOTE: the counter array is reset on purpose; a debounce that was in
         // progress when reset hit must not complete after release.
         for (int i = 0; i < N_IN; i++) begin
            cnt_q[i] <= '0;
         end
      end else begin
         for (int i = 0; i < N_IN; i++) begin
            if (sync_out[i] == stable[i]) begin
               cnt_q[i] <= '0;
            end else if (cnt_q[i] == CNT_LAST) begin
               stable[i] <= sync_out[i];
               cnt_q[i]  <= '0;
            end else begin
               cnt_q[i] <= cnt_q[i] + CNT_W'(1);
            end
         end
      end
   end

   // stable_d is the debounced level one edge late; comparing it with stable
   // gives the edge detection for both the press pulses and the change strobe.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         stable_d      <= '0;
         pulse_q       <= '0;
         input_changed <= 1'b0;
      end else begin
         stable_d      <= stable;
         pulse_q       <= stable & ~stable_d & PULSE_MASK;
         input_changed <= |((stable ^ stable_d) & ~PULSE_MASK);
      end
   end

   assign device_inputs = (stable & ~PULSE_MASK) | pulse_q;

endmodule

// File: tb/tb_ppb_input_conditioner.sv
// -----------------------------------------------------------------------------
// tb_ppb_input_conditioner
//
// Bench for ppb_input_conditioner with N_IN=60, SYNC_STAGES=2,
// DEBOUNCE_CYCLES=4 and the default momentary mask (bits 1 and 13).
// A reference model predicts the outputs after every edge from a window of
// raw samples; predictions are queued and a monitor compares them against the
// DUT one time unit after each rising edge. Directed scenarios add explicit
// timing and pulse-count checks on top.
// -----------------------------------------------------------------------------
module tb_ppb_input_conditioner;

   localparam int N    = 60;
   localparam int SYNC = 2;
   localparam int DEB  = 4;

   logic           clk = 1'b0;
   logic           reset;
   logic [0:N-1]   raw_inputs;
   logic [0:N-1]   device_inputs;
   logic           input_changed;

   always #5 clk = ~clk;

   ppb_input_conditioner #(
      .N_IN            (N),
      .SYNC_STAGES     (SYNC),
      .DEBOUNCE_CYCLES (DEB)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .raw_inputs    (raw_inputs),
      .device_inputs (device_inputs),
      .input_changed (input_changed)
   );

   typedef struct packed {
      logic [0:N-1] dev;
      logic         chg;
   } exp_t;

   exp_t sb_q[$];
   int   total = 0;
   int   bad   = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [0:N-1] bitv(input int i);
      logic [0:N-1] v;
      v    = '0;
      v[i] = 1'b1;
      return v;
   endfunction

   // ---------------------------------------------------------------------------
   // Reference model. samp[0] is the raw value sampled at this edge, samp[k]
   // the one sampled k edges earlier. The debouncer sees raw delayed by SYNC
   // edges, and a bit's stable level flips when the last DEB delayed samples
   // all agree on the opposite value. Reset wipes the sample history and all
   // levels.
   // ---------------------------------------------------------------------------
   logic [0:N-1] mask;
   logic [0:N-1] s1;   // stable level after the previous edge
   logic [0:N-1] s2;   // stable level after the edge before that
   logic [0:N-1] samp[$];

   task automatic model_edge(input logic [0:N-1] r, input logic rs);
      logic [0:N-1] and_all, or_all, s_new, pulse;
      exp_t         e;
      samp.push_front(rs ? '0 : r);
      void'(samp.pop_back());
      if (rs) begin
         for (int k = 0; k < samp.size(); k++) samp[k] = '0;
         s1    = '0;
         s2    = '0;
         e.dev = '0;
         e.chg = 1'b0;
      end else begin
         and_all = '1;
         or_all  = '0;
         for (int k = SYNC; k < SYNC + DEB; k++) begin
            and_all &= samp[k];
            or_all  |= samp[k];
         end
         s_new = (s1 | and_all) & or_all;
         pulse = s1 & ~s2 & mask;
         e.dev = (s_new & ~mask) | pulse;
         e.chg = |((s1 ^ s2) & ~mask);
         s2    = s1;
         s1    = s_new;
      end
      sb_q.push_back(e);
   endtask

   // Monitor: one prediction per edge, compared away from the edge.
   always @(posedge clk) begin
      exp_t e;
      #1;
      if (sb_q.size() > 0) begin
         e = sb_q.pop_front();
         check("sb_dev", device_inputs, e.dev);
         check("sb_chg", input_changed, e.chg);
      end
   end

   // ---------------------------------------------------------------------------
   // Observation of two watched bits for the directed checks.
   // ---------------------------------------------------------------------------
   int   cyc, watch_a, watch_b, rise_a, rise_b, rises, hi_cnt, strobes, strobe_at;
   logic prev_a, prev_b;

   task automatic clear_obs(input int a, input int b);
      watch_a   = a;
      watch_b   = b;
      cyc       = 0;
      rise_a    = -1;
      rise_b    = -1;
      rises     = 0;
      hi_cnt    = 0;
      strobes   = 0;
      strobe_at = -1;
      prev_a    = device_inputs[a];
      prev_b    = device_inputs[b];
   endtask

   task automatic step(input logic [0:N-1] r, input logic rs);
      @(negedge clk);
      raw_inputs = r;
      reset      = rs;
      @(posedge clk);
      model_edge(r, rs);
      #2;
      cyc++;
      if (device_inputs[watch_a] && !prev_a) begin
         rises++;
         if (rise_a < 0) rise_a = cyc;
      end
      if (device_inputs[watch_a]) hi_cnt++;
      if (device_inputs[watch_b] && !prev_b && rise_b < 0) rise_b = cyc;
      prev_a = device_inputs[watch_a];
      prev_b = device_inputs[watch_b];
      if (input_changed) begin
         strobes++;
         strobe_at = cyc;
      end
   endtask

   task automatic run(input logic [0:N-1] r, input int n);
      repeat (n) step(r, 1'b0);
   endtask

   initial begin
      logic [0:N-1] rv;
      int           hold_start;

      mask     = '0;
      mask[1]  = 1'b1;
      mask[13] = 1'b1;
      s1       = '0;
      s2       = '0;
      for (int k = 0; k < SYNC + DEB; k++) samp.push_back('0);
      reset      = 1'b1;
      raw_inputs = '1;

      // 1: reset held with every raw bit high
      clear_obs(0, 0);
      repeat (10) begin
         step('1, 1'b1);
         check("rst_dev", device_inputs, 0);
         check("rst_chg", input_changed, 0);
      end
      run('0, 5);

      // 2: level bit 0 latency and change strobe
      clear_obs(0, 0);
      run(bitv(0), 10);
      check("lvl_rise_edge", rise_a, 6);
      check("lvl_high_cycles", hi_cnt, 5);
      check("lvl_strobe_cnt", strobes, 1);
      check("lvl_strobe_edge", strobe_at, 7);
      run('0, 10);

      // 3: glitch of 3 cycles rejected, 4 cycles accepted
      clear_obs(5, 5);
      run(bitv(5), 3);
      run('0, 12);
      check("glitch_rises", rises, 0);
      check("glitch_strobes", strobes, 0);
      clear_obs(5, 5);
      run(bitv(5), 4);
      run('0, 12);
      check("min_rises", rises, 1);
      check("min_high_cycles", hi_cnt, 4);
      check("min_strobes", strobes, 2);

      // 4: held momentary button gives one pulse per press
      clear_obs(1, 1);
      run(bitv(1), 50);
      check("btn_pulses", rises, 1);
      check("btn_width", hi_cnt, 1);
      check("btn_edge", rise_a, 7);
      check("btn_strobes", strobes, 0);
      run('0, 10);
      clear_obs(1, 1);
      run(bitv(1), 20);
      check("btn2_pulses", rises, 1);
      check("btn2_edge", rise_a, 7);
      run('0, 10);

      // 5: bouncing AR_load, then held
      clear_obs(13, 13);
      for (int j = 0; j < 10; j++) run((j % 2 == 0) ? bitv(13) : '0, 2);
      hold_start = cyc;
      run(bitv(13), 20);
      check("bounce_pulses", rises, 1);
      check("bounce_edge", rise_a, hold_start + 7);
      check("bounce_strobes", strobes, 0);
      run('0, 10);

      // 6: reset in the middle of a debounce
      clear_obs(3, 3);
      run(bitv(3), 2);
      repeat (3) begin
         step(bitv(3), 1'b1);
         check("mid_rst_dev", device_inputs, 0);
         check("mid_rst_chg", input_changed, 0);
      end
      clear_obs(3, 3);
      run(bitv(3), 10);
      check("post_rst_edge", rise_a, 6);
      run('0, 10);

      // 7: two level bits accepted together, one strobe
      clear_obs(0, 3);
      run(bitv(0) | bitv(3), 10);
      check("pair_rise_a", rise_a, 6);
      check("pair_rise_b", rise_b, 6);
      check("pair_strobes", strobes, 1);
      run('0, 10);

      // Random traffic with occasional resets, checked by the scoreboard only
      rv = '0;
      repeat (1500) begin
         for (int i = 0; i < N; i++) begin
            if ($urandom_range(15) == 0) rv[i] = ~rv[i];
         end
         step(rv, ($urandom_range(299) == 0));
      end
      run('0, 12);

      @(negedge clk);
      check("sb_drained", sb_q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
